// File: rtl/baccarat_fsm.sv
// Baccarat game sequencer: deals four cards, applies the third-card rules, then lights the winner.
// Define BACCARAT_FSM_DBG_EN to expose the state encoding on state_dbg.
module baccarat_fsm (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
`ifdef BACCARAT_FSM_DBG_EN
  ,
  output logic [3:0] state_dbg
`endif
);

  typedef enum logic [3:0] {
    S_P1     = 4'd0,
    S_D1     = 4'd1,
    S_P2     = 4'd2,
    S_D2     = 4'd3,
    S_EVAL1  = 4'd4,
    S_P3     = 4'd5,
    S_EVAL2  = 4'd6,
    S_D3     = 4'd7,
    S_RESULT = 4'd8
  } state_t;

  state_t     state;
  logic [3:0] pval;
  logic       natural, player_draw, dealer_draw;

  // Face cards and tens count as zero.
  assign pval        = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
  assign natural     = (pscore >= 4'd8) || (dscore >= 4'd8);
  assign player_draw = (pscore <= 4'd5);

  always_comb begin
    dealer_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
      4'd3:             dealer_draw = (pval != 4'd8);
      4'd4:             dealer_draw = (pval >= 4'd2) && (pval <= 4'd7);
      4'd5:             dealer_draw = (pval >= 4'd4) && (pval <= 4'd7);
      4'd6:             dealer_draw = (pval >= 4'd6) && (pval <= 4'd7);
      default:          dealer_draw = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state <= S_P1;
    end else begin
      case (state)
        S_P1:    state <= S_D1;
        S_D1:    state <= S_P2;
        S_P2:    state <= S_D2;
        S_D2:    state <= S_EVAL1;
        S_EVAL1: begin
          if (natural)                  state <= S_RESULT;
          else if (player_draw)         state <= S_P3;
          else if (dscore <= 4'd5)      state <= S_D3;
          else                          state <= S_RESULT;
        end
        S_P3:    state <= S_EVAL2;
        S_EVAL2: state <= dealer_draw ? S_D3 : S_RESULT;
        S_D3:    state <= S_RESULT;
        default: state <= S_RESULT;
      endcase
    end
  end

  // Outputs are gated by resetb so they drop the instant reset asserts
  // and load_pcard1 rises on release without waiting for a clock.
  assign load_pcard1      = resetb && (state == S_P1);
  assign load_dcard1      = resetb && (state == S_D1);
  assign load_pcard2      = resetb && (state == S_P2);
  assign load_dcard2      = resetb && (state == S_D2);
  assign load_pcard3      = resetb && (state == S_P3);
  assign load_dcard3      = resetb && (state == S_D3);
  assign player_win_light = resetb && (state == S_RESULT) && (pscore >= dscore);
  assign dealer_win_light = resetb && (state == S_RESULT) && (dscore >= pscore);

`ifdef BACCARAT_FSM_DBG_EN
  assign state_dbg = resetb ? state : 4'd0;
`endif

endmodule
